// File: rtl/enet_crc_pkg.sv
// rtl/enet_crc_pkg.sv - shared CRC-32 constants and framer state encoding
// Purpose: constants for the reflected Ethernet CRC-32 and the pad/CRC framer states.
// Ports: none (package).
package enet_crc_pkg;

  localparam logic [31:0] CRC32_TAPS    = 32'hedb88320;
  localparam logic [31:0] CRC32_INIT    = 32'hffffffff;
  // Register value left after running the update over a frame plus its own FCS.
  localparam logic [31:0] CRC32_RESIDUE = 32'hdebb20e3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAD  = 2'd2,
    CRC  = 2'd3
  } state_e;

endpackage

// File: rtl/addecrc_pad_if.sv
// rtl/addecrc_pad_if.sv - octet stream bundle between TX source and pad/CRC appender
// Purpose: groups the per-frame controls, input octet stream and output stream/status.
// Ports: i_en, i_pad_en, i_v, i_d (source -> appender); o_v, o_d, o_busy, o_err (appender -> sink).
interface addecrc_pad_if;
  logic       i_en;
  logic       i_pad_en;
  logic       i_v;
  logic [7:0] i_d;
  logic       o_v;
  logic [7:0] o_d;
  logic       o_busy;
  logic       o_err;

  modport master (output i_en, i_pad_en, i_v, i_d,
                  input  o_v, o_d, o_busy, o_err);
  modport slave  (input  i_en, i_pad_en, i_v, i_d,
                  output o_v, o_d, o_busy, o_err);
endinterface

// File: rtl/crc32_octet.sv
// rtl/crc32_octet.sv - combinational reflected CRC-32 update for one octet
// Purpose: next CRC register value after absorbing one octet, LSB first.
// Ports: crc_i (current register), octet_i (data octet), crc_o (updated register).
module crc32_octet
  import enet_crc_pkg::*;
#(
  parameter logic [31:0] TAPS = CRC32_TAPS
) (
  input  logic [31:0] crc_i,
  input  logic [7:0]  octet_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  // Eight chained per-bit steps: shift right, fold in TAPS when the bit
  // leaving the register differs from the incoming data bit.
  always_comb begin
    c = crc_i;
    for (int i = 0; i < 8; i++) begin
      c = {1'b0, c[31:1]} ^ ({32{c[0] ^ octet_i[i]}} & TAPS);
    end
    crc_o = c;
  end

endmodule

// File: rtl/addecrc_pad.sv
// rtl/addecrc_pad.sv - TX octet framer: min-length zero padding plus appended CRC-32
// Purpose: forwards an octet frame with one cycle latency, pads short frames, appends CRC LSB first.
// Ports: i_clk, i_reset (async, active high), i_ce (clock enable), bus (slave side of addecrc_pad_if).
module addecrc_pad
  import enet_crc_pkg::*;
#(
  parameter logic [31:0] TAPS     = CRC32_TAPS,
  parameter logic [31:0] INIT     = CRC32_INIT,
  parameter logic [31:0] XOR_OUT  = 32'hffffffff,
  parameter int          MIN_LEN  = 60,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  addecrc_pad_if.slave  bus
);

  localparam int LEN_W = (MIN_LEN < 1) ? 1 : $clog2(MIN_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = (MIN_LEN > 0) ? LEN_W'(1) : '0;

  state_e           state_q, state_d;
  logic [31:0]      crc_q, crc_d, crc_nx;
  logic [LEN_W-1:0] len_q, len_d, len_inc;
  logic [1:0]       idx_q, idx_d;
  logic             en_q, en_d, pad_q, pad_d;
  logic             ov_q, ov_d, busy_q, busy_d, err_q, err_d;
  logic [7:0]       od_q, od_d;
  logic [7:0]       octet_sel, crc_lane;
  logic             pad_more;

  // Data octets feed the CRC only while accepting; every other update absorbs PAD_BYTE.
  assign octet_sel = ((state_q == IDLE || state_q == DATA) && bus.i_v) ? bus.i_d : PAD_BYTE;

  crc32_octet #(.TAPS(TAPS)) u_crc (
    .crc_i   (crc_q),
    .octet_i (octet_sel),
    .crc_o   (crc_nx)
  );

  assign len_inc  = (len_q < LEN_MAX) ? len_q + LEN_W'(1) : len_q;
  assign pad_more = pad_q && (len_q < LEN_MAX);
  // idx is 0 on entry to CRC, so the same lane select serves the first octet.
  assign crc_lane = 8'((crc_q ^ XOR_OUT) >> {idx_q, 3'b000});

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    len_d   = len_q;
    idx_d   = idx_q;
    en_d    = en_q;
    pad_d   = pad_q;
    ov_d    = 1'b0;
    od_d    = od_q;
    // Octets offered while padding/CRC are dropped and flagged.
    err_d   = bus.i_v && busy_q;
    case (state_q)
      IDLE: begin
        crc_d = INIT;
        if (bus.i_v) begin
          en_d    = bus.i_en;
          pad_d   = bus.i_pad_en;
          ov_d    = 1'b1;
          od_d    = bus.i_d;
          crc_d   = crc_nx;
          len_d   = LEN_ONE;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus.i_v) begin
          ov_d  = 1'b1;
          od_d  = bus.i_d;
          crc_d = crc_nx;
          len_d = len_inc;
        end else if (pad_more) begin
          ov_d    = 1'b1;
          od_d    = PAD_BYTE;
          crc_d   = crc_nx;
          len_d   = len_inc;
          state_d = PAD;
        end else if (en_q) begin
          ov_d    = 1'b1;
          od_d    = crc_lane;
          idx_d   = 2'd1;
          state_d = CRC;
        end else begin
          crc_d   = INIT;
          state_d = IDLE;
        end
      end
      PAD: begin
        if (pad_more) begin
          ov_d  = 1'b1;
          od_d  = PAD_BYTE;
          crc_d = crc_nx;
          len_d = len_inc;
        end else if (en_q) begin
          ov_d    = 1'b1;
          od_d    = crc_lane;
          idx_d   = 2'd1;
          state_d = CRC;
        end else begin
          crc_d   = INIT;
          state_d = IDLE;
        end
      end
      CRC: begin
        // idx wraps to 0 after lane 3 has gone out; that marks the closing edge.
        if (idx_q != 2'd0) begin
          ov_d  = 1'b1;
          od_d  = crc_lane;
          idx_d = idx_q + 2'd1;
        end else begin
          crc_d   = INIT;
          state_d = IDLE;
        end
      end
      default: begin
        crc_d   = INIT;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == PAD) || (state_d == CRC);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      len_q   <= '0;
      idx_q   <= 2'd0;
      en_q    <= 1'b0;
      pad_q   <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= 8'h00;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (i_ce) begin
      state_q <= state_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      pad_q   <= pad_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_v    = ov_q;
  assign bus.o_d    = od_q;
  assign bus.o_busy = busy_q;
  assign bus.o_err  = err_q;

endmodule

// File: doc/addecrc_pad.md
Name: addecrc_pad

Overview:
- Successor to the Ethernet TX CRC appender.
- Takes an octet stream, zero-pads short frames to a parametrised minimum length, then appends a parametrised 32-bit CRC, LSB-first.
- Sits between the TX packet source and the nibble/PHY serializer in the enet path, gated by the shared i_ce strobe.
- Adds over the previous block:
  - minimum-length padding;
  - per-frame mode latching;
  - a busy indication;
  - protocol-error reporting;
  - fully parametrised CRC polynomial, init value and output XOR.

Parameters:
TAPS, 32'hedb88320, reflected CRC polynomial
INIT, 32'hffffffff, CRC register value at idle/frame start
XOR_OUT, 32'hffffffff, XOR applied to each emitted CRC octet (per byte lane)
MIN_LEN, 60, minimum payload octets before CRC; 0 disables padding regardless of i_pad_en
PAD_BYTE, 8'h00, fill octet

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_ce  in  1  clock enable; all state holds when low
i_en  in  1  append CRC for this frame
i_pad_en  in  1  pad this frame to MIN_LEN
i_v  in  1  input octet valid; frame = contiguous i_v run (sampled on i_ce)
i_d  in  8  input octet
o_v  out  1  output octet valid
o_d  out  8  output octet
o_busy  out  1  high while in PAD or CRC; upstream must hold i_v low
o_err  out  1  one-i_ce-cycle pulse when i_v is seen while busy

Behaviour:
- Reset (async assert, sync release):
  - o_v=0, o_d=0, o_busy=0, o_err=0.
  - crc=INIT, state=IDLE, len=0, byte index=0.
  - Reset mid-frame aborts the frame immediately; no partial CRC is emitted.
- All transitions below occur only on i_clk edges with i_ce=1. With i_ce=0, every register, including o_err, holds.
- Latency: i_v/i_d to o_v/o_d is exactly one i_ce cycle. Padding/CRC octets follow the last data octet with no gap, so o_v stays continuous.
- crc_next = reflected byte update of crc with octet x: LSB-first, shift right, XOR TAPS when (lsb ^ data bit) is set.
- Length counter:
  - width $clog2(MIN_LEN+1), minimum 1;
  - increments per data or pad octet;
  - saturates at MIN_LEN.
- States:
  - IDLE:
    - o_v=0, crc=INIT.
    - On i_v: latch en_r=i_en and pad_r=i_pad_en (held for the whole frame; later changes ignored).
    - Same edge: o_v=1, o_d=i_d, crc=crc_next(i_d), len=1, go to DATA.
  - DATA:
    - On i_v: o_d=i_d, crc=crc_next(i_d), len++.
    - On !i_v with pad_r and len<MIN_LEN: go to PAD.
      - Emit PAD_BYTE this edge, crc=crc_next(PAD_BYTE), len++.
    - Else if !i_v and en_r: go to CRC.
      - Emit crc[7:0]^XOR_OUT[7:0], idx=1.
    - Else if !i_v: o_v=0, crc=INIT, go to IDLE.
  - PAD:
    - Emit PAD_BYTE, update crc, len++ each edge until len reaches MIN_LEN.
    - Then go to CRC (emit first CRC octet on that same edge) if en_r, else go to IDLE with o_v=0.
  - CRC:
    - Emit (crc>>(8*idx))[7:0]^XOR_OUT lane idx for idx=1..3.
    - After idx 3 is emitted, the next edge sets o_v=0, crc=INIT, state=IDLE.
    - The CRC register is not shifted; idx selects the lane.
- Output length per frame:
  - pad_r and en_r: max(N,MIN_LEN)+4 octets;
  - no pad, en_r: N+4;
  - neither: N.
- o_busy=1 in PAD and CRC states (registered, same edge as state).
- i_v=1 while o_busy:
  - octet is dropped, o_err=1 for that cycle;
  - the PAD/CRC sequence is unaffected;
  - a new frame may start only from IDLE.
- Back-to-back frames:
  - i_v high on the edge the state returns to IDLE counts as a violation (still busy);
  - i_v on the following edge starts a new frame.
- Invariant: state==IDLE implies crc==INIT and o_v==0.

Decomposition:
- Package enet_crc_pkg:
  - CRC32_TAPS, CRC32_INIT, CRC32_RESIDUE (32'hdebb20e3) constants;
  - state enum {IDLE, DATA, PAD, CRC}.
- Sub-module crc32_octet: combinational next-CRC from (crc, octet, TAPS), implemented as an 8-entry XOR table of per-bit equations.
  - Reused later by the RX CRC checker.

Test Plan:
- "123456789" (0x31..0x39), en=1, pad=0, i_ce=1 -> 13 octets out; last four are 26 39 F4 CB.
- 1-octet frame 0xAA, en=1, pad=1 -> 64 octets; octet0=0xAA, octets 1..59=0x00; crc32_octet run over all 64 output octets leaves register == 32'hdebb20e3.
- 60-octet and 61-octet frames, pad=1, en=1 -> 64 and 65 octets; no PAD state visited; o_busy high exactly 4 cycles.
- en=0, pad=1, 10-octet frame -> 60 octets, o_v drops right after the last pad; en=0, pad=0 -> pass-through, o_v deasserts 1 cycle after i_v.
- i_ce toggling 1/0 randomly on the 9-octet case -> identical octet sequence to the i_ce=1 run; i_v asserted during the CRC state -> o_err pulses, CRC octets unchanged.
- i_reset asserted asynchronously in the middle of the PAD state -> o_v=0, o_busy=0 immediately; the next frame produces a correct CRC.
